// File: rtl/axil_ctl_pkg.sv
// Shared definitions for the AXI4-Lite control/status slave.
// Holds the register word indices, STATUS / IRQ bit positions, the AXI
// response encodings and a helper that says whether a word slot is mapped.
package axil_ctl_pkg;

    // Word index = byte address [4:2]
    localparam logic [2:0] REG_CMD      = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_IRQ_EN   = 3'd2;
    localparam logic [2:0] REG_IRQ_STAT = 3'd3;
    localparam logic [2:0] REG_PARAM0   = 3'd4;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    // IRQ_EN / IRQ_STAT bit positions
    localparam int IRQ_DONE = 0;
    localparam int IRQ_ERR  = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Packed so that the struct drops straight into STATUS[2:0]
    typedef struct packed {
        logic err;
        logic done;
        logic busy;
    } status_t;

    // Slots 0..3 always exist; parameter slots follow from REG_PARAM0.
    function automatic logic reg_mapped(input logic [2:0] idx, input int num_param);
        return (int'(idx) < int'(REG_PARAM0) + num_param);
    endfunction

endpackage

// File: rtl/axil_ctl_core_if.sv
// Core-side control: busy/done/err tracker, one-cycle mode pulse generator
// and the maskable level interrupt.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_accept        strobe from the AXI front end: CMD write accepted
//   cmd_mode          mode value to pulse out with cmd_accept
//   done_in, err_in   completion pulse from the core and its error qualifier
//   irq_en_we/wdata   IRQ_EN register write
//   irq_stat_w1c      IRQ_STAT bits to clear (already gated by the front end)
//   mode_out          one-cycle mode pulse, 0 when idle
//   status            busy/done/err
//   irq_en, irq_stat  register contents for readback
//   irq               registered level interrupt
module axil_ctl_core_if
    import axil_ctl_pkg::*;
#(
    parameter int MODE_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_accept,
    input  logic [MODE_WIDTH-1:0] cmd_mode,
    input  logic                  done_in,
    input  logic                  err_in,
    input  logic                  irq_en_we,
    input  logic [1:0]            irq_en_wdata,
    input  logic [1:0]            irq_stat_w1c,
    output logic [MODE_WIDTH-1:0] mode_out,
    output status_t               status,
    output logic [1:0]            irq_en,
    output logic [1:0]            irq_stat,
    output logic                  irq
);

    logic [MODE_WIDTH-1:0] mode_q, mode_d;
    status_t               status_q, status_d;
    logic [1:0]            irq_en_q, irq_en_d;
    logic [1:0]            irq_stat_q, irq_stat_d;
    logic                  irq_q, irq_d;
    logic                  done_fire;
    logic [1:0]            irq_stat_set;

    // Completion only counts while an operation is in flight. cmd_accept
    // needs busy=0, so the two never fire in the same cycle.
    assign done_fire    = done_in & status_q.busy;
    assign irq_stat_set = {done_fire & err_in, done_fire};

    always_comb begin
        mode_d     = cmd_accept ? cmd_mode : '0;
        status_d   = status_q;
        irq_en_d   = irq_en_we ? irq_en_wdata : irq_en_q;
        // Set has priority over a simultaneous write-1-to-clear
        irq_stat_d = (irq_stat_q & ~irq_stat_w1c) | irq_stat_set;
        irq_d      = |(irq_stat_q & irq_en_q);
        if (cmd_accept) begin
            status_d.busy = 1'b1;
            status_d.done = 1'b0;
            status_d.err  = 1'b0;
        end else if (done_fire) begin
            status_d.busy = 1'b0;
            status_d.done = 1'b1;
            status_d.err  = err_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= '0;
            status_q   <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            status_q   <= status_d;
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            irq_q      <= irq_d;
        end
    end

    assign mode_out = mode_q;
    assign status   = status_q;
    assign irq_en   = irq_en_q;
    assign irq_stat = irq_stat_q;
    assign irq      = irq_q;

endmodule

// File: rtl/axil_ctl_regs.sv
// AXI4-Lite control/status slave for the Ncc-Sign core.
// A CMD write becomes a one-cycle oCTL_MODE pulse; STATUS tracks the core,
// IRQ_EN / IRQ_STAT drive oIRQ, PARAMn registers feed oCTL_PARAM.
// Ports: standard AXI4-Lite slave (S_AXI_*), oCTL_MODE mode pulse,
// oCTL_PARAM flattened parameters (PARAM0 in LSBs), iCTL_DONE/iCTL_ERR
// completion from the core, oIRQ level interrupt.
// ARESETN is assumed release-synchronised upstream; assertion is async.
// With NUM_PARAM=0, oCTL_PARAM is a single constant-zero bit.
module axil_ctl_regs
    import axil_ctl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int MODE_WIDTH         = 3,
    parameter int NUM_PARAM          = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [MODE_WIDTH-1:0]           oCTL_MODE,
    output logic [((NUM_PARAM > 0) ? 32*NUM_PARAM : 1)-1:0] oCTL_PARAM,
    input  logic                            iCTL_DONE,
    input  logic                            iCTL_ERR,
    output logic                            oIRQ
);

    localparam int PARAM_SLOTS = (NUM_PARAM > 0) ? NUM_PARAM : 1;
    localparam int PARAM_OUT_W = (NUM_PARAM > 0) ? 32*NUM_PARAM : 1;

    logic clk, rst_n;
    assign clk   = S_AXI_ACLK;
    assign rst_n = S_AXI_ARESETN;

    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;

    logic        wr_hs, rd_hs, cmd_ok, cmd_accept, irq_en_we;
    logic [1:0]  irq_stat_w1c, irq_en, irq_stat;
    logic [2:0]  wr_idx, rd_idx;
    logic [31:0] rd_word;
    logic [32*PARAM_SLOTS-1:0] param_flat;
    status_t     status;

    assign wr_idx = S_AXI_AWADDR[4:2];
    assign rd_idx = S_AXI_ARADDR[4:2];

    // Ready is registered and excludes itself, so it is high for one cycle
    // per transfer; waiting on !bvalid_q adds the idle cycle after a response.
    assign wr_hs = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_hs = arready_q & S_AXI_ARVALID;

    // Busy comes from the registered state: a done pulse in this same cycle
    // does not free the slot yet.
    assign cmd_ok     = ~status.busy & S_AXI_WSTRB[0] & (S_AXI_WDATA[MODE_WIDTH-1:0] != '0);
    assign cmd_accept = wr_hs & (wr_idx == REG_CMD) & cmd_ok;
    // IRQ fields live in byte 0, so only that strobe commits them
    assign irq_en_we    = wr_hs & (wr_idx == REG_IRQ_EN) & S_AXI_WSTRB[0];
    assign irq_stat_w1c = (wr_hs && wr_idx == REG_IRQ_STAT && S_AXI_WSTRB[0]) ?
                          S_AXI_WDATA[1:0] : 2'b00;

    always_comb begin
        awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (wr_hs) begin
            bvalid_d = 1'b1;
            if (!reg_mapped(wr_idx, NUM_PARAM) || (wr_idx == REG_CMD && !cmd_ok))
                bresp_d = RESP_SLVERR;
            else
                bresp_d = RESP_OKAY;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            REG_STATUS:   rd_word = {29'b0, status};
            REG_IRQ_EN:   rd_word = {30'b0, irq_en};
            REG_IRQ_STAT: rd_word = {30'b0, irq_stat};
            default: begin
                for (int i = 0; i < NUM_PARAM; i++)
                    if (rd_idx == REG_PARAM0 + 3'(i))
                        rd_word = param_flat[32*i +: 32];
            end
        endcase
    end

    always_comb begin
        arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (rd_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = reg_mapped(rd_idx, NUM_PARAM) ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = rd_word;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PARAM; gi++) begin : g_param
            logic [31:0] word_q, word_d;
            always_comb begin
                word_d = word_q;
                if (wr_hs && wr_idx == REG_PARAM0 + 3'(gi))
                    for (int b = 0; b < 4; b++)
                        if (S_AXI_WSTRB[b])
                            word_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) word_q <= '0;
                else        word_q <= word_d;
            end
            assign param_flat[32*gi +: 32] = word_q;
        end
        if (NUM_PARAM == 0) begin : g_no_param
            assign param_flat = '0;
        end
    endgenerate

    axil_ctl_core_if #(.MODE_WIDTH(MODE_WIDTH)) u_core_if (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_accept   (cmd_accept),
        .cmd_mode     (S_AXI_WDATA[MODE_WIDTH-1:0]),
        .done_in      (iCTL_DONE),
        .err_in       (iCTL_ERR),
        .irq_en_we    (irq_en_we),
        .irq_en_wdata (S_AXI_WDATA[1:0]),
        .irq_stat_w1c (irq_stat_w1c),
        .mode_out     (oCTL_MODE),
        .status       (status),
        .irq_en       (irq_en),
        .irq_stat     (irq_stat),
        .irq          (oIRQ)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign oCTL_PARAM    = param_flat[PARAM_OUT_W-1:0];

    logic unused_inputs;
    assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: doc/axil_ctl_regs.md
Name: axil_ctl_regs

Overview:
- Parametrised AXI4-Lite control/status slave that succeeds the single-register mode-pulse controller.
- Converts a CMD register write into a one-cycle mode pulse to the crypto core.
- Tracks core busy/done/error, exposes parameter registers to the core, and raises a maskable level interrupt to the PS.
- Sits between the Zynq PS GP port and the Ncc-Sign core top.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word slots.
- MODE_WIDTH, 3, width of the mode field and of oCTL_MODE; range 1..8.
- NUM_PARAM, 4, number of 32-bit parameter registers at 0x10 upward; range 0..4.

Ports:
- S_AXI_ACLK  in  1  single system clock.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID/S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID/S_AXI_RREADY  out/in  1  read-data handshake.
- oCTL_MODE  out  MODE_WIDTH  one-cycle start pulse carrying the mode; 0 when idle.
- oCTL_PARAM  out  32*NUM_PARAM  flattened parameter registers; PARAM0 in the LSBs.
- iCTL_DONE  in  1  one-cycle pulse from the core: operation finished.
- iCTL_ERR  in  1  qualifies iCTL_DONE; the operation failed.
- oIRQ  out  1  level interrupt.

Behaviour:
- Reset (async assert, sync release): all outputs and registers 0, including READY/VALID, oCTL_MODE, oIRQ and every register.

Register map (word index = addr[4:2]):
- 0 CMD: write-only; reads 0.
- 1 STATUS: read-only; bit0 busy, bit1 done (sticky), bit2 err (sticky).
- 2 IRQ_EN: read/write; bit0 done-irq, bit1 err-irq.
- 3 IRQ_STAT: write-1-to-clear; bit0 done, bit1 err.
- 4..4+NUM_PARAM-1 PARAMn: read/write, honour WSTRB.
- Other slots: unmapped.

Write channel:
- Accept only when AWVALID & WVALID & !BVALID.
- AWREADY and WREADY go high together for exactly one cycle.
- BVALID rises the next cycle and holds until BREADY; then one idle cycle before the next accept.
- No outstanding-transaction overlap.

Read channel:
- ARREADY high for one cycle when ARVALID & !RVALID.
- RVALID and RDATA registered the next cycle; held stable until RREADY.
- Unmapped read or read of CMD: RDATA = 0.

Responses:
- BRESP/RRESP = OKAY (2'b00), except:
  - unmapped write or read: SLVERR (2'b10); write has no effect.
  - CMD write rejected: SLVERR (2'b10).

CMD write:
- Accepted when busy=0, WSTRB[0]=1 and WDATA[MODE_WIDTH-1:0] != 0.
- On accept, the cycle after the handshake:
  - oCTL_MODE = latched mode for exactly 1 cycle, coinciding with BVALID rising;
  - busy <= 1; done and err cleared.
- Any other CMD write is rejected: SLVERR, no pulse, state unchanged.
- Busy is evaluated from the registered value in the handshake cycle. A done pulse arriving in that same cycle does not make the CMD acceptable.

Core completion:
- iCTL_DONE while busy: busy <= 0; done <= 1; err <= iCTL_ERR; IRQ_STAT[0] <= 1; IRQ_STAT[1] <= iCTL_ERR.
- iCTL_DONE while idle is ignored.
- W1C on IRQ_STAT in the same cycle as a set: the set wins.

Interrupt:
- oIRQ registered: |(IRQ_STAT & IRQ_EN), so 1-cycle latency after the status update.
- Enabling an already-pending status raises oIRQ one cycle after the IRQ_EN write commits.

Other rules:
- PARAM registers can be written while busy; the core must sample them at the oCTL_MODE pulse.
- Reset mid-transaction: all VALID/READY drop immediately, busy clears, and any pending oCTL_MODE pulse is lost.

Decomposition:
- Package axil_ctl_pkg holds:
  - register word indices: REG_CMD=0, REG_STATUS=1, REG_IRQ_EN=2, REG_IRQ_STAT=3, REG_PARAM0=4;
  - status bit positions;
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- One sub-module: axil_ctl_core_if. It contains the busy/done/err tracker, the mode-pulse generator and the IRQ logic, driven by a decoded "cmd_accept + mode" strobe from the AXI front end.

Test Plan:
- Reset release, wait 5 cycles, write CMD=7 -> BRESP=00; oCTL_MODE=3'b111 for exactly one cycle aligned with BVALID, then 000; STATUS read = 0x1.
- While busy, write CMD=3 -> BRESP=10, no oCTL_MODE pulse; pulse iCTL_DONE -> STATUS = 0x2, IRQ_STAT = 0x1.
- IRQ_EN=0x1, then done pulse -> oIRQ=1 one cycle after IRQ_STAT sets; write IRQ_STAT=0x1 -> oIRQ=0 two cycles later.
- Done pulse with iCTL_ERR=1 in the same cycle as a W1C of IRQ_STAT -> IRQ_STAT = 0x3, STATUS = 0x6.
- Write PARAM1=0xDEADBEEF with WSTRB=4'b0011 over 0 -> readback 0x0000BEEF, and oCTL_PARAM[63:32] matches; read addr 0x1C with NUM_PARAM=2 -> RRESP=10, RDATA=0.
- Write CMD=0 -> SLVERR; then drop ARESETN mid-read with RVALID high and RREADY=0 -> RVALID=0 immediately, all registers 0.
